alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_core.sv | 71 +++++++
 rtl/alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential Hack-style ALU (alu_seq / alu_core).
//   mode_t   : operation selector (Hack function, shift left, logical shift
//              right, multiply low half)
//   state_t  : control FSM states (IDLE, BUSY, DONE)
//   rsel_t   : which pre-"no" result alu_core forwards to its output stage
//   SEL_*    : bit positions inside the 6-bit sel control word
//   FLAG_*   : bit positions inside the one-hot 3-bit result class flag
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        MODE_HACK = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_MUL  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // HACK   : combinational Hack function of the preprocessed operands
    // PASS_X : preprocessed x unchanged (zero-length shift)
    // EXT    : value supplied by the sequential datapath in alu_seq
    typedef enum logic [1:0] {
        RSEL_HACK   = 2'b00,
        RSEL_PASS_X = 2'b01,
        RSEL_EXT    = 2'b10
    } rsel_t;

    localparam int SEL_ZA = 0;
    localparam int SEL_NA = 1;
    localparam int SEL_ZB = 2;
    localparam int SEL_NB = 3;
    localparam int SEL_F  = 4;
    localparam int SEL_NO = 5;

    localparam int FLAG_NEG  = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_POS  = 2;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational part of the ALU: operand preprocessing (za/na/zb/nb),
// the Hack function (x+y or x&y), the final "no" inversion and the one-hot
// result-class flag.
// Ports:
//   i_a, i_b   [WIDTH] raw operands
//   i_sel      [6]     control word (za, na, zb, nb, f, no)
//   i_rsel     rsel_t  source of the pre-inversion result
//   i_r_ext    [WIDTH] externally computed result (shift / multiply)
//   i_no       [1]     invert the selected result
//   o_x, o_y   [WIDTH] preprocessed operands
//   o_out      [WIDTH] final result
//   o_flag     [3]     one-hot class of o_out: [0] neg, [1] zero, [2] pos
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [5:0]       i_sel,
    input  rsel_t            i_rsel,
    input  logic [WIDTH-1:0] i_r_ext,
    input  logic             i_no,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_out,
    output logic [2:0]       o_flag
);

    logic [WIDTH-1:0] w_hack;
    logic [WIDTH-1:0] w_r;

    always_comb begin
        o_x = i_sel[SEL_ZA] ? '0 : i_a;
        if (i_sel[SEL_NA]) begin
            o_x = ~o_x;
        end
        o_y = i_sel[SEL_ZB] ? '0 : i_b;
        if (i_sel[SEL_NB]) begin
            o_y = ~o_y;
        end
    end

    assign w_hack = i_sel[SEL_F] ? (o_x & o_y) : (o_x + o_y);

    always_comb begin
        w_r = i_r_ext;
        case (i_rsel)
            RSEL_HACK:   w_r = w_hack;
            RSEL_PASS_X: w_r = o_x;
            default:     w_r = i_r_ext;
        endcase
    end

    assign o_out = i_no ? ~w_r : w_r;

    always_comb begin
        o_flag = '0;
        if (o_out[WIDTH-1]) begin
            o_flag[FLAG_NEG] = 1'b1;
        end else if (o_out == '0) begin
            o_flag[FLAG_ZERO] = 1'b1;
        end else begin
            o_flag[FLAG_POS] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential Hack-style ALU with valid/ready handshakes on both sides.
// Mode 00 completes in one cycle; shifts take one cycle per bit position and
// multiply is a WIDTH-cycle shift-add. One operation in flight at a time.
//
// Handshake: an operation transfers in on a rising edge where
// in_valid && in_ready (in_ready is high only in IDLE); a result transfers out
// on a rising edge where out_valid && out_ready (out_valid is high only in
// DONE). alu_out/flag are held stable for as long as out_valid stays high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake
//   a, b   [WIDTH]    operands
//   sel    [6]        za, na, zb, nb, f, no
//   mode   [2]        00 Hack, 01 shl, 10 lsr, 11 multiply (if MUL_EN)
//   out_valid/out_ready result handshake
//   alu_out [WIDTH]   registered result
//   flag    [3]       one-hot class: [0] neg, [1] zero, [2] pos
//   o_dbg_state       current FSM state
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       sel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [2:0]       flag,
    output state_t           o_dbg_state
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mx;
    logic [WIDTH-1:0] r_my;
    mode_t            r_mode;
    logic             r_no;

    mode_t            w_mode_eff;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [SH_W-1:0]  w_shamt;
    logic             w_accept;
    logic             w_busy_last;
    logic [WIDTH-1:0] w_busy_res;
    rsel_t            w_core_rsel;
    logic             w_core_no;
    logic [WIDTH-1:0] w_core_out;
    logic [2:0]       w_core_flag;

    // Without the multiplier, mode 11 falls back to the Hack function.
    always_comb begin
        w_mode_eff = mode_t'(mode);
        if (MUL_EN == 0 && mode == 2'b11) begin
            w_mode_eff = MODE_HACK;
        end
    end

    assign w_shamt     = w_y[SH_W-1:0];
    assign w_accept    = (r_state == S_IDLE) && in_valid;
    assign w_busy_last = (r_cnt == CNT_W'(1));

    // Value the accumulator / shifter takes on this BUSY cycle. On the last
    // BUSY cycle it is also the pre-inversion final result.
    always_comb begin
        w_busy_res = r_mx;
        case (r_mode)
            MODE_SHL: w_busy_res = r_mx << 1;
            MODE_SHR: w_busy_res = r_mx >> 1;
            MODE_MUL: w_busy_res = r_my[0] ? (r_acc + r_mx) : r_acc;
            default:  w_busy_res = r_mx;
        endcase
    end

    // In IDLE the core sees the live request (Hack result, or x itself for
    // a zero-length shift); in BUSY it only finishes the sequential result
    // with the latched "no" bit.
    always_comb begin
        w_core_rsel = RSEL_HACK;
        w_core_no   = sel[SEL_NO];
        if (r_state == S_BUSY) begin
            w_core_rsel = RSEL_EXT;
            w_core_no   = r_no;
        end else if (w_mode_eff != MODE_HACK) begin
            w_core_rsel = RSEL_PASS_X;
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_a    (a),
        .i_b    (b),
        .i_sel  (sel),
        .i_rsel (w_core_rsel),
        .i_r_ext(w_busy_res),
        .i_no   (w_core_no),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_out  (w_core_out),
        .o_flag (w_core_flag)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_mode_eff == MODE_HACK ||
                        (w_mode_eff != MODE_MUL && w_shamt == '0)) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (w_busy_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: counter, shift/accumulate registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mx    <= '0;
            r_my    <= '0;
            r_mode  <= MODE_HACK;
            r_no    <= 1'b0;
            alu_out <= '0;
            flag    <= '0;
        end else begin
            if (w_accept) begin
                r_mode <= w_mode_eff;
                r_no   <= sel[SEL_NO];
                r_mx   <= w_x;
                r_my   <= w_y;
                r_acc  <= '0;
                if (w_next_state == S_DONE) begin
                    r_cnt   <= '0;
                    alu_out <= w_core_out;
                    flag    <= w_core_flag;
                end else if (w_mode_eff == MODE_MUL) begin
                    r_cnt <= CNT_W'(WIDTH);
                end else begin
                    r_cnt <= CNT_W'(w_shamt);
                end
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_mode == MODE_MUL) begin
                    r_acc <= w_busy_res;
                    r_mx  <= r_mx << 1;
                    r_my  <= r_my >> 1;
                end else begin
                    r_mx <= w_busy_res;
                end
                if (w_busy_last) begin
                    alu_out <= w_core_out;
                    flag    <= w_core_flag;
                end
            end
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   sel;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic [2:0]   flag;
    state_t       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    alu_seq #(
        .WIDTH (W),
        .MUL_EN(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .flag       (flag),
        .o_dbg_state(dbg_state)
    );

    typedef struct {
        logic [1:0]   mode;
        logic [5:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic [2:0]   exp_flag;
        int           exp_lat;
    } vec_t;

    vec_t vecs[12];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model straight from the operation definitions.
    task automatic model(input logic [1:0] m, input logic [5:0] s,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] o, output logic [2:0] f, output int lat);
        int unsigned x, y, r, sh;
        x = s[0] ? 0 : av;
        if (s[1]) x = ~x & 32'hFFFF;
        y = s[2] ? 0 : bv;
        if (s[3]) y = ~y & 32'hFFFF;
        sh = y % 16;
        case (m)
            2'b00: begin r = s[4] ? (x & y) : (x + y); lat = 1; end
            2'b01: begin r = x << sh; lat = 1 + sh; end
            2'b10: begin r = x >> sh; lat = 1 + sh; end
            default: begin r = x * y; lat = 1 + W; end
        endcase
        r = r & 32'hFFFF;
        if (s[5]) r = ~r & 32'hFFFF;
        o = r[W-1:0];
        if (o[W-1]) f = 3'b001;
        else if (o == 0) f = 3'b010;
        else f = 3'b100;
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic [1:0] m, input logic [5:0] s,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] e_out, input logic [2:0] e_flag,
                          input int e_lat, input int bp, input string nm);
        int waited;
        int lat;
        logic [W-1:0] exp_v;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({nm, " idle before accept"}, waited, 0);
        exp_q.push_back(e_out);
        a = av; b = bv; sel = s; mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        // scramble request lines; in_valid stays high and must be ignored
        a = W'($urandom); b = W'($urandom); sel = 6'($urandom); mode = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin
            check({nm, " in_ready busy"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, lat, e_lat);
        exp_v = exp_q.pop_front();
        check({nm, " out"}, alu_out, exp_v);
        check({nm, " flag"}, flag, e_flag);
        check({nm, " in_ready done"}, in_ready, 0);
        check({nm, " state done"}, 32'(dbg_state), 32'(S_DONE));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); sel = 6'($urandom); mode = 2'($urandom);
            @(posedge clk); #1;
            check({nm, " hold out"}, alu_out, exp_v);
            check({nm, " hold flag"}, flag, e_flag);
            check({nm, " hold valid"}, out_valid, 1);
            check({nm, " hold in_ready"}, in_ready, 0);
        end
        // release with in_valid still high: must go to IDLE, not accept
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({nm, " release in_ready"}, in_ready, 1);
        check({nm, " release out_valid"}, out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- test ----------------
    initial begin
        logic [W-1:0] r_a, r_b, e_o;
        logic [1:0]   r_m;
        logic [5:0]   r_s;
        logic [2:0]   e_f;
        int           e_l;
        logic         stale;

        vecs[0]  = '{2'b00, 6'b000000, 16'd5,    16'd7,    16'h000C, 3'b100, 1};
        vecs[1]  = '{2'b00, 6'b110000, 16'h00F0, 16'h0FF0, 16'hFF0F, 3'b001, 1};
        vecs[2]  = '{2'b00, 6'b000101, 16'h00F0, 16'h0FF0, 16'h0000, 3'b010, 1};
        vecs[3]  = '{2'b11, 6'b000000, 16'd300,  16'd300,  16'h5F90, 3'b100, 17};
        vecs[4]  = '{2'b10, 6'b000000, 16'h8000, 16'd15,   16'h0001, 3'b100, 16};
        vecs[5]  = '{2'b01, 6'b000000, 16'h1234, 16'd0,    16'h1234, 3'b100, 1};
        vecs[6]  = '{2'b01, 6'b000000, 16'h0001, 16'd4,    16'h0010, 3'b100, 5};
        vecs[7]  = '{2'b00, 6'b000010, 16'h0000, 16'h0000, 16'hFFFF, 3'b001, 1};
        vecs[8]  = '{2'b10, 6'b100000, 16'hFFFF, 16'h0013, 16'hE000, 3'b001, 4};
        vecs[9]  = '{2'b11, 6'b000001, 16'h1234, 16'h5678, 16'h0000, 3'b010, 17};
        vecs[10] = '{2'b00, 6'b010000, 16'hFF00, 16'h0FF0, 16'h0F00, 3'b100, 1};
        vecs[11] = '{2'b11, 6'b000000, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b100, 17};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = '0; mode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset alu_out", alu_out, 0);
        check("reset flag", flag, 0);
        check("reset state", 32'(dbg_state), 32'(S_IDLE));
        rst = 1'b0;

        // directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].mode, vecs[i].sel, vecs[i].a, vecs[i].b,
                   vecs[i].exp_out, vecs[i].exp_flag, vecs[i].exp_lat, 0,
                   $sformatf("vec%0d", i));
        end

        // long backpressure, then back-to-back accept after release
        run_op(2'b00, 6'b000000, 16'd5, 16'd7, 16'h000C, 3'b100, 1, 5, "bp5");
        run_op(2'b00, 6'b000000, 16'd1, 16'd2, 16'h0003, 3'b100, 1, 0, "after_bp");

        // reset 8 cycles into a multiply: discarded, no stale result
        @(negedge clk);
        a = 16'd300; b = 16'd300; sel = 6'b000000; mode = 2'b11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst in_ready", in_ready, 1);
        check("midrst out_valid", out_valid, 0);
        check("midrst alu_out", alu_out, 0);
        check("midrst flag", flag, 0);
        check("midrst state", 32'(dbg_state), 32'(S_IDLE));
        stale = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("midrst no stale result", stale, 0);

        // randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            r_m = 2'($urandom);
            r_s = 6'($urandom);
            r_a = W'($urandom);
            r_b = W'($urandom);
            model(r_m, r_s, r_a, r_b, e_o, e_f, e_l);
            run_op(r_m, r_s, r_a, r_b, e_o, e_f, e_l, $urandom_range(0, 2),
                   $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
